// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants, counter widths and the pixel pipeline stage type
package vga_pkg;
    localparam int H_VIS   = 640;
    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BP    = 48;
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_VIS   = 480;
    localparam int V_FP    = 10;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 33;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int XW      = $clog2(H_TOTAL);
    localparam int YW      = $clog2(V_TOTAL);

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          act;
        logic          hs;
        logic          vs;
        logic          valid;
    } pix_stage_t;
endpackage

// File: rtl/vga_sync_gen_div.sv
// pixel_tick_div: one-clock pix_en pulse every CLK_DIV system clocks
module pixel_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clock,
    input  logic reset,
    output logic pix_en
);
    localparam int W = $clog2(CLK_DIV);
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] div_cnt;

    // count 0..CLK_DIV-1 and wrap on the tick
    always_ff @(posedge clock) begin
        if (reset) div_cnt <= '0;
        else       div_cnt <= pix_en ? '0 : div_cnt + 1'b1;
    end

    assign pix_en = div_cnt == LAST;
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: pixel tick, x/y sync decode, LAT-tick alignment pipeline and frame pulses
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter bit H_POL   = 1'b0,
    parameter bit V_POL   = 1'b0,
    parameter int LAT     = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    output logic          pix_en,
    output logic [XW-1:0] xo,
    output logic [YW-1:0] yo,
    output logic          active,
    output logic          hsync,
    output logic          vsync,
    output logic          line_start,
    output logic          frame_start,
    output logic [7:0]    frame_cnt
);
    localparam logic [XW-1:0] HV  = XW'(H_VIS);
    localparam logic [XW-1:0] HS0 = XW'(H_VIS + H_FP);
    localparam logic [XW-1:0] HS1 = XW'(H_VIS + H_FP + H_SYNC);
    localparam logic [YW-1:0] VV  = YW'(V_VIS);
    localparam logic [YW-1:0] VS0 = YW'(V_VIS + V_FP);
    localparam logic [YW-1:0] VS1 = YW'(V_VIS + V_FP + V_SYNC);

    pix_stage_t s0, ld, f;
    pix_stage_t pipe [LAT];
    logic       ls_n, fs_n;

    pixel_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clock (clock),
        .reset (reset),
        .pix_en(pix_en)
    );

    // out-of-range x/y fall outside every window, so they decode as blank without sync
    always_comb s0 = '{x: x, y: y,
                       act: (x < HV) && (y < VV),
                       hs: (x >= HS0) && (x < HS1),
                       vs: (y >= VS0) && (y < VS1),
                       valid: 1'b1};

    // shift the decoded pixel through LAT stages, one step per pixel tick
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else if (pix_en) begin
            pipe[0] <= s0;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    generate
        if (LAT == 1) begin : g_ld_dec
            assign ld = s0;
        end else begin : g_ld_pipe
            assign ld = pipe[LAT-2];
        end
    endgenerate

    assign f           = pipe[LAT-1];
    assign xo          = f.valid ? f.x : '0;
    assign yo          = f.valid ? f.y : '0;
    assign active      = f.valid && f.act;
    assign hsync       = (f.valid && f.hs) ? H_POL : ~H_POL;
    assign vsync       = (f.valid && f.vs) ? V_POL : ~V_POL;
    assign ls_n        = pix_en && ld.valid && (ld.x == '0);
    assign fs_n        = ls_n && (ld.y == '0);

    // pulses mark the clock in which the output stage holds column 0 / pixel (0,0)
    always_ff @(posedge clock) begin
        if (reset) begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            line_start  <= ls_n;
            frame_start <= fs_n;
            if (fs_n) frame_cnt <= frame_cnt + 8'd1;
        end
    end
endmodule
